// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one valid/ready request, waits LATENCY cycles,
// then presents a single registered response beat with read data or write ack.
module dmem_responder #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 4096,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    input  logic        req_wen,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [32:0] LIMIT    = 33'(DEPTH) << 2;
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [3:0]         cnt, cnt_nx;
    logic [31:0]        mem [DEPTH];
    logic [31:0]        rdata_r;
    logic               err_r;
    logic [31:0]        offset;
    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic               accept;
    logic               unused_wmask;

    // Unsigned wrap of the offset makes addresses below BASE fall out of range too.
    assign offset       = req_addr - BASE;
    assign in_range     = {1'b0, offset} < LIMIT;
    assign idx          = offset[IDX_W+1:2];
    assign accept       = req_valid && (state == IDLE) && !rst;
    assign unused_wmask = ^req_wmask[7:4];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                    end else begin
                        cnt_nx   = CNT_INIT;
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            RESP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                err_r   <= !in_range;
                rdata_r <= (in_range && !req_wen) ? mem[idx] : '0;
            end
        end
    end

    // NOTE: the storage array has no reset; only accepted in-range writes touch it.
    always_ff @(posedge clk) begin
        if (accept && req_wen && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wmask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven transactions on a LATENCY=2
// instance, hand sequences for backpressure/reset, and a LATENCY=0 throughput run.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          LAT_A = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_wen = 1'b0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic [7:0]  a_req_wmask = '0;
    logic        a_rsp_valid, a_rsp_ready = 1'b1, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_wen = 1'b0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [7:0]  b_req_wmask = '0;
    logic        b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[17];

    always #5 clk = ~clk;

    dmem_responder #(.BASE(BASE), .DEPTH(4096), .LATENCY(LAT_A)) dut (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_wmask(a_req_wmask), .req_wen(a_req_wen),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.BASE(BASE), .DEPTH(4096), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_wmask(b_req_wmask), .req_wen(b_req_wen),
        .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic sb_pop_cmp(input string name, input logic [31:0] rdata, input logic err);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: response with empty scoreboard, got %h/%b", name, rdata, err);
        end else begin
            e = sb.pop_front();
            check({name, " rdata"}, rdata, e.rdata);
            check_bit({name, " err"}, err, e.err);
        end
    endtask

    // Starts just after a rising edge with the LATENCY=2 instance idle and rsp_ready high.
    task automatic req_a(input string name, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [7:0] mask,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        a_req_valid = 1'b1;
        a_req_wen   = wen;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_wmask = mask;
        @(negedge clk);
        check_bit({name, " req_ready"}, a_req_ready, 1'b1);
        sb.push_back('{exp_rdata, exp_err});
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_req_wen   = 1'b0;
        n = 0;
        @(negedge clk);
        while (!a_rsp_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({name, " latency"}, 32'(n), 32'(LAT_A));
        sb_pop_cmp(name, a_rsp_rdata, a_rsp_err);
        @(posedge clk);
        #1;
        check_bit({name, " ready after rsp"}, a_req_ready, 1'b1);
        check_bit({name, " valid after rsp"}, a_rsp_valid, 1'b0);
    endtask

    initial begin
        int  n;
        logic seen;
        time t_acc, t_prev;

        vecs[0]  = '{"wr_deadbeef",  1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0,         1'b0};
        vecs[1]  = '{"rd_deadbeef",  1'b0, 32'h8000_0010, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{"rd_unaligned", 1'b0, 32'h8000_0013, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{"wr_full",      1'b1, 32'h8000_0020, 32'h1122_3344, 8'h0F, 32'h0,         1'b0};
        vecs[4]  = '{"wr_mask05",    1'b1, 32'h8000_0020, 32'hAABB_CCDD, 8'h05, 32'h0,         1'b0};
        vecs[5]  = '{"rd_masked",    1'b0, 32'h8000_0020, 32'h0,         8'h00, 32'h11BB_33DD, 1'b0};
        vecs[6]  = '{"wr_maskF0",    1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 8'hF0, 32'h0,         1'b0};
        vecs[7]  = '{"rd_after_F0",  1'b0, 32'h8000_0020, 32'h0,         8'h00, 32'h11BB_33DD, 1'b0};
        vecs[8]  = '{"wr_last",      1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 8'h0F, 32'h0,         1'b0};
        vecs[9]  = '{"wr_below",     1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 8'h0F, 32'h0,         1'b1};
        vecs[10] = '{"rd_last",      1'b0, 32'h8000_3FFC, 32'h0,         8'h00, 32'hCAFE_F00D, 1'b0};
        vecs[11] = '{"rd_end",       1'b0, 32'h8000_4000, 32'h0,         8'h00, 32'h0,         1'b1};
        vecs[12] = '{"wr_first",     1'b1, 32'h8000_0000, 32'h0BAD_F00D, 8'h0F, 32'h0,         1'b0};
        vecs[13] = '{"rd_first",     1'b0, 32'h8000_0000, 32'h0,         8'h00, 32'h0BAD_F00D, 1'b0};
        vecs[14] = '{"rd_below",     1'b0, 32'h7FFF_FFFC, 32'h0,         8'h00, 32'h0,         1'b1};
        vecs[15] = '{"wr_end",       1'b1, 32'h8000_4000, 32'h5555_5555, 8'h0F, 32'h0,         1'b1};
        vecs[16] = '{"rd_first2",    1'b0, 32'h8000_0000, 32'h0,         8'h00, 32'h0BAD_F00D, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("reset req_ready", a_req_ready, 1'b1);
        check_bit("reset rsp_valid", a_rsp_valid, 1'b0);
        check("reset rsp_rdata", a_rsp_rdata, 32'h0);
        check_bit("reset rsp_err", a_rsp_err, 1'b0);
        check_bit("reset b req_ready", b_req_ready, 1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            req_a(vecs[i].name, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                  vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: response held for 5 cycles while req_* is driven with a write.
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b1;
        a_req_wen   = 1'b0;
        a_req_addr  = 32'h8000_0010;
        sb.push_back('{32'hDEAD_BEEF, 1'b0});
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!a_rsp_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("bp latency", 32'(n), 32'(LAT_A));
        sb_pop_cmp("bp first", a_rsp_rdata, a_rsp_err);
        a_req_valid = 1'b1;
        a_req_wen   = 1'b1;
        a_req_wdata = 32'h0;
        a_req_wmask = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_bit("bp rsp_valid", a_rsp_valid, 1'b1);
            check("bp rsp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
            check_bit("bp rsp_err", a_rsp_err, 1'b0);
            check_bit("bp req_ready", a_req_ready, 1'b0);
        end
        a_req_valid = 1'b0;
        a_req_wen   = 1'b0;
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_bit("bp release req_ready", a_req_ready, 1'b1);
        check_bit("bp release rsp_valid", a_rsp_valid, 1'b0);
        req_a("bp ignored write", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_BEEF, 1'b0);

        // Reset during WAIT of a write: response discarded, write stays committed.
        req_a("pre_wr40", 1'b1, 32'h8000_0040, 32'h0101_0101, 8'h0F, 32'h0, 1'b0);
        a_req_valid = 1'b1;
        a_req_wen   = 1'b1;
        a_req_addr  = 32'h8000_0030;
        a_req_wdata = 32'h5A5A_5A5A;
        a_req_wmask = 8'h0F;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_req_wen   = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("rst_wait req_ready", a_req_ready, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            seen = seen | a_rsp_valid;
            @(negedge clk);
        end
        check_bit("rst_wait no rsp", seen, 1'b0);
        @(posedge clk);
        #1;

        // A request presented in the reset cycle must not be accepted.
        rst = 1'b1;
        a_req_valid = 1'b1;
        a_req_wen   = 1'b1;
        a_req_addr  = 32'h8000_0040;
        a_req_wdata = 32'h0202_0202;
        a_req_wmask = 8'h0F;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_req_valid = 1'b0;
        a_req_wen   = 1'b0;
        @(negedge clk);
        check_bit("rst_req req_ready", a_req_ready, 1'b1);
        check_bit("rst_req rsp_valid", a_rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        req_a("rd_committed", 1'b0, 32'h8000_0030, 32'h0, 8'h00, 32'h5A5A_5A5A, 1'b0);
        req_a("rd_not_taken", 1'b0, 32'h8000_0040, 32'h0, 8'h00, 32'h0101_0101, 1'b0);

        // LATENCY=0 instance, rsp_ready tied high: 4 writes then 4 back-to-back reads.
        t_prev = 0;
        b_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_req_wen   = (i < 4);
            b_req_addr  = BASE + 32'(4 * (i % 4));
            b_req_wdata = 32'hC0DE_0000 | 32'(i);
            b_req_wmask = 8'h0F;
            @(negedge clk);
            check_bit("b req_ready", b_req_ready, 1'b1);
            if (i < 4) sb.push_back('{32'h0, 1'b0});
            else       sb.push_back('{32'hC0DE_0000 | 32'(i - 4), 1'b0});
            @(posedge clk);
            t_acc = $time;
            if (i > 0) check("b accept spacing", 32'(t_acc - t_prev), 32'd20);
            t_prev = t_acc;
            @(negedge clk);
            check_bit("b rsp_valid", b_rsp_valid, 1'b1);
            check_bit("b req_ready in rsp", b_req_ready, 1'b0);
            sb_pop_cmp("b rsp", b_rsp_rdata, b_rsp_err);
            @(posedge clk);
            #1;
        end
        b_req_valid = 1'b0;
        check_bit("b final req_ready", b_req_ready, 1'b1);
        check_bit("b final rsp_valid", b_rsp_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the NPC core: the memory-side end of the LSU's valid/ready load/store handshake. It accepts one request (address, write data, byte mask, write enable), holds it for a programmable latency, and returns exactly one response beat. The response carries read data or a write acknowledge, plus an error flag. It replaces the zero-latency SRAM behind the LSU so the LSU's wait states and backpressure paths can be exercised.

## Interface
Parameters:
- BASE, 32'h8000_0000, byte address of word 0
- DEPTH, 4096, number of 32-bit words; power of two
- LATENCY, 2, extra wait cycles between request acceptance and response valid; 0..15

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_addr  in  32  byte address; bits [1:0] ignored, the word is aligned
- req_wdata  in  32  store data, already lane-aligned
- req_wmask  in  8  byte-lane enables; [3:0] map to bytes 3..0 and [7:4] are ignored
- req_wen  in  1  1 = write, 0 = read
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  address outside [BASE, BASE+4*DEPTH)

## Operation
- Storage: DEPTH×32 register array, not reset.
  - Index = (req_addr − BASE) >> 2.
  - In range when req_addr − BASE < 4*DEPTH, compared as an unsigned 32-bit value.
- States: IDLE, WAIT, RESP. Encoding is free; any undefined code returns to IDLE.
- IDLE:
  - req_ready = 1.
  - On the handshake (req_valid & req_ready) the request is accepted at that edge:
    - Write in range: each byte lane i with req_wmask[i]=1 takes req_wdata[8i+7:8i]; lanes with mask 0 are unchanged. Latch rdata_r = 0, err_r = 0.
    - Read in range: latch rdata_r = mem[index], the value before any write at this edge; there is none, since a request is either a read or a write. Latch err_r = 0.
    - Out of range: no write occurs. Latch rdata_r = 0, err_r = 1.
    - If LATENCY = 0, go to RESP. Otherwise load cnt = LATENCY−1 and go to WAIT.
- WAIT:
  - req_ready = 0 and rsp_valid = 0.
  - If cnt = 0, go to RESP; otherwise decrement cnt.
- RESP:
  - rsp_valid = 1, rsp_rdata = rdata_r, rsp_err = err_r, all held stable.
  - On rsp_ready, go to IDLE. Otherwise stay in RESP indefinitely.
- The response is a registered word; no read-modify of memory happens after acceptance.
- Only one request is outstanding. No pipelining and no request buffering.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1 in the cycle after the reset edge.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, cnt = 0.
- Request latency: if the handshake happens at edge k, rsp_valid first asserts in the cycle after edge k+LATENCY.
  - With LATENCY = 0, rsp_valid is high in the cycle immediately after acceptance.
- Response handshake at edge m: rsp_valid = 0 and req_ready = 1 in the cycle after m.
  - Back-to-back throughput is one request per LATENCY+2 cycles when rsp_ready is held high.
- req_ready is a pure function of state; it does not depend combinationally on req_valid.
- rsp_valid never depends combinationally on rsp_ready.
- Outputs are registered or decoded from state only.
- rsp_rdata and rsp_err change only on acceptance edges and on reset.
- Reset mid-transaction: state returns to IDLE and the pending response is discarded.
  - A write accepted before the reset edge stays committed.
  - A request presented in the same cycle as rst is not accepted.
- req_* inputs are ignored outside IDLE; changing them during WAIT/RESP has no effect.

## Test plan
- Reset, then LATENCY=2:
  - Write 0xDEADBEEF to 0x8000_0010 with mask 0x0F; response arrives 2 cycles later with rdata=0, err=0.
  - Read 0x8000_0010 → rsp_rdata = 0xDEADBEEF, rsp_valid first seen exactly 2 cycles after acceptance.
- Byte masking:
  - Write 0x11223344 with mask 0x0F, then write 0xAABBCCDD with mask 0x05 to the same address.
  - Read → 0x11BB33DD. Also check that mask bits [7:4] = 0xF have no effect.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0.
  - On rsp_ready=1, req_ready=1 the next cycle.
- Out of range:
  - Write to 0x7FFF_FFFC → err=1, memory unchanged.
  - Read BASE+4*DEPTH → err=1, rdata=0.
  - Read BASE+4*DEPTH−4 → err=0.
- LATENCY=0 with rsp_ready tied high, 4 back-to-back reads:
  - One response every 2 cycles.
  - rsp_valid is high in the cycle right after each acceptance.
- Reset asserted during WAIT of a write:
  - rsp_valid never rises for it, and req_ready=1 after reset.
  - A subsequent read of the same address returns the written data.
